if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter, drives the instruction-memory request handshake, and loads the IF/ID pipeline register. It consumes the hazard unit's PCWriteEnable, IFIDWriteEnable and resolved Branch, so stalls and taken branches resolved in ID take effect here.

---
 rtl/if_pkg.sv | 21 ++
 rtl/if_stage_if.sv | 10 +
 rtl/ifid_register.sv | 25 ++
 rtl/if_stage.sv | 161 ++++++++++++++++
 tb/tb_if_stage.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        REDIRECT
    } state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pcplus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = {NOP_INSTR, 32'h0000_0000, 1'b0};

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/response handshake between the fetch stage and memory.
interface if_stage_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemValid;
    logic [31:0] IMemData;

    modport master (output IMemReq, output IMemAddr, input IMemValid, input IMemData);
    modport slave  (input IMemReq, input IMemAddr, output IMemValid, output IMemData);
endinterface

// File: rtl/ifid_register.sv
// IF/ID pipeline register: loads a record or a bubble when enabled, bubble on reset.
module ifid_register
    import if_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);

    ifid_t q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= IFID_BUBBLE;
        end else if (load) begin
            q_reg <= bubble ? IFID_BUBBLE : d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem handshake, IF/ID load, stall and redirect handling.
// Define IF_DELAY_SLOT_EN to keep the instruction fetched alongside a redirect (delay slot).
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         PCWriteEnable,
    input  logic         IFIDWriteEnable,
    input  logic         Branch,
    input  logic [31:0]  BranchTarget,
    if_stage_if.master   imem,
    output logic [31:0]  IFIDInstruction,
    output logic [31:0]  IFIDPCPlus4,
    output logic         IFIDValid,
    output logic [31:0]  PC
);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] pending_reg, pending_next;
    ifid_t       buf_reg, buf_next;

    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_target;
    ifid_t       fetched;
    ifid_t       ifid_d;
    ifid_t       ifid_q;
    logic        ifid_load;
    logic        ifid_bubble;

    assign redirect        = Branch & PCWriteEnable;
    assign pc_plus4        = pc_reg + 32'd4;
    // A redirect arriving while one is already pending replaces it.
    assign redirect_target = redirect ? BranchTarget : pending_reg;
    assign fetched         = {imem.IMemData, pc_plus4, 1'b1};

    assign imem.IMemReq  = Reset & (state_reg != HOLD);
    assign imem.IMemAddr = pc_reg;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            pending_reg <= 32'h0000_0000;
            buf_reg     <= IFID_BUBBLE;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            pending_reg <= pending_next;
            buf_reg     <= buf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        pending_next = pending_reg;
        buf_next     = buf_reg;
        ifid_load    = 1'b0;
        ifid_bubble  = 1'b0;
        ifid_d       = fetched;
        case (state_reg)
            FETCH: begin
                if (imem.IMemValid) begin
`ifdef IF_DELAY_SLOT_EN
                    pc_next = redirect ? BranchTarget : pc_plus4;
                    if (IFIDWriteEnable) begin
                        ifid_load = 1'b1;
                    end else begin
                        buf_next   = fetched;
                        state_next = HOLD;
                    end
`else
                    if (redirect) begin
                        pc_next     = BranchTarget;
                        ifid_load   = 1'b1;
                        ifid_bubble = 1'b1;
                    end else begin
                        pc_next = pc_plus4;
                        if (IFIDWriteEnable) begin
                            ifid_load = 1'b1;
                        end else begin
                            buf_next   = fetched;
                            state_next = HOLD;
                        end
                    end
`endif
                end else begin
                    // Address must stay stable until the response, so park the target.
                    ifid_load   = IFIDWriteEnable;
                    ifid_bubble = 1'b1;
                    if (redirect) begin
                        pending_next = BranchTarget;
                        state_next   = REDIRECT;
                    end
                end
            end
            HOLD: begin
                ifid_d = buf_reg;
`ifdef IF_DELAY_SLOT_EN
                if (redirect) begin
                    pc_next = BranchTarget;
                end
                if (IFIDWriteEnable) begin
                    ifid_load  = 1'b1;
                    state_next = FETCH;
                end
`else
                if (redirect) begin
                    pc_next     = BranchTarget;
                    buf_next    = IFID_BUBBLE;
                    ifid_load   = IFIDWriteEnable;
                    ifid_bubble = 1'b1;
                    state_next  = FETCH;
                end else if (IFIDWriteEnable) begin
                    ifid_load  = 1'b1;
                    state_next = FETCH;
                end
`endif
            end
            REDIRECT: begin
                pending_next = redirect_target;
                ifid_load    = IFIDWriteEnable;
                ifid_bubble  = 1'b1;
                if (imem.IMemValid) begin
                    pc_next    = redirect_target;
                    state_next = FETCH;
`ifdef IF_DELAY_SLOT_EN
                    ifid_bubble = 1'b0;
                    if (!IFIDWriteEnable) begin
                        buf_next   = fetched;
                        state_next = HOLD;
                    end
`endif
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    ifid_register u_ifid (
        .clk    (Clock),
        .rst_n  (Reset),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign IFIDInstruction = ifid_q.instruction;
    assign IFIDPCPlus4     = ifid_q.pcplus4;
    assign IFIDValid       = ifid_q.valid;
    assign PC              = pc_reg;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: queue-based fetch model checked every cycle plus literal pins.
module tb_if_stage;

    localparam logic [31:0] RPC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] p4;
    } ent_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        PCWriteEnable = 1'b1;
    logic        IFIDWriteEnable = 1'b1;
    logic        Branch = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic [31:0] IFIDInstruction, IFIDPCPlus4, PC;
    logic        IFIDValid;

    if_stage_if mif ();

    if_stage #(.RESET_PC(RPC)) dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .PCWriteEnable   (PCWriteEnable),
        .IFIDWriteEnable (IFIDWriteEnable),
        .Branch          (Branch),
        .BranchTarget    (BranchTarget),
        .imem            (mif),
        .IFIDInstruction (IFIDInstruction),
        .IFIDPCPlus4     (IFIDPCPlus4),
        .IFIDValid       (IFIDValid),
        .PC              (PC)
    );

    always #5 Clock = ~Clock;

    // Memory: returns its own address as data after `waits` extra cycles.
    int   waits = 0;
    int   wait_cnt = 0;
    logic mem_valid;
    assign mem_valid     = mif.IMemReq && (wait_cnt == waits);
    assign mif.IMemValid = mem_valid;
    assign mif.IMemData  = mif.IMemAddr;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset)                         wait_cnt <= 0;
        else if (!mif.IMemReq || mem_valid) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end

    int n_vec = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pc, an optional stalled entry, an optional parked redirect target.
    logic [31:0] m_pc = RPC;
    logic [31:0] m_i  = 32'h0;
    logic [31:0] m_p4 = 32'h0;
    logic        m_v  = 1'b0;
    ent_t        hold_q[$];
    logic [31:0] redir_q[$];

    task automatic model_step();
        logic redir;
        logic mv;
        ent_t e;
        mv    = mem_valid;
        redir = Branch & PCWriteEnable;
        if (!Reset) begin
            m_pc = RPC; m_i = 0; m_p4 = 0; m_v = 0;
            hold_q.delete(); redir_q.delete();
        end else if (hold_q.size() > 0) begin
            if (redir) begin
                hold_q.delete();
                m_pc = BranchTarget;
                if (IFIDWriteEnable) begin m_i = 0; m_p4 = 0; m_v = 0; end
            end else if (IFIDWriteEnable) begin
                e = hold_q.pop_front();
                m_i = e.instr; m_p4 = e.p4; m_v = 1;
            end
        end else if (redir_q.size() > 0) begin
            if (redir) redir_q[0] = BranchTarget;
            if (IFIDWriteEnable) begin m_i = 0; m_p4 = 0; m_v = 0; end
            if (mv) m_pc = redir_q.pop_front();
        end else if (mv && !redir) begin
            e.instr = m_pc;
            e.p4    = m_pc + 32'd4;
            if (IFIDWriteEnable) begin m_i = e.instr; m_p4 = e.p4; m_v = 1; end
            else hold_q.push_back(e);
            m_pc = m_pc + 32'd4;
        end else if (mv) begin
            m_i = 0; m_p4 = 0; m_v = 0;
            m_pc = BranchTarget;
        end else begin
            if (IFIDWriteEnable) begin m_i = 0; m_p4 = 0; m_v = 0; end
            if (redir) redir_q.push_back(BranchTarget);
        end
    endtask

    initial forever begin
        @(posedge Clock or negedge Reset);
        model_step();
    end

    initial forever begin
        @(negedge Clock);
        if (check_en) begin
            chk("req",   {31'h0, mif.IMemReq}, {31'h0, Reset && (hold_q.size() == 0)});
            chk("addr",  mif.IMemAddr, m_pc);
            chk("pc",    PC, m_pc);
            chk("instr", IFIDInstruction, m_i);
            chk("pc4",   IFIDPCPlus4, m_p4);
            chk("valid", {31'h0, IFIDValid}, {31'h0, m_v});
        end
    end

    task automatic cyc(input logic br, input logic [31:0] tgt, input logic pcwe, input logic ifwe);
        Branch = br; BranchTarget = tgt; PCWriteEnable = pcwe; IFIDWriteEnable = ifwe;
        @(negedge Clock); #1;
        $display("cyc br=%0d tgt=%h pcwe=%0d ifwe=%0d -> req=%0d addr=%h ifid=%h/%h/%0d",
                 br, tgt, pcwe, ifwe, mif.IMemReq, mif.IMemAddr,
                 IFIDInstruction, IFIDPCPlus4, IFIDValid);
    endtask

    initial begin
        @(negedge Clock); #1;
        chk("rst_req",   {31'h0, mif.IMemReq}, 32'h0);
        chk("rst_pc",    PC, RPC);
        chk("rst_valid", {31'h0, IFIDValid}, 32'h0);
        Reset = 1'b1;
        #1;
        chk("rel_addr", mif.IMemAddr, RPC);
        check_en = 1'b1;

        // Sequential zero-wait fetch from RESET_PC.
        cyc(0, 0, 1, 1);
        chk("seq_pc4",   IFIDPCPlus4, 32'h0040_0004);
        chk("seq_valid", {31'h0, IFIDValid}, 32'h1);
        chk("seq_addr",  mif.IMemAddr, 32'h0040_0004);
        cyc(0, 0, 1, 1);
        cyc(1, 32'h0, 1, 1);
        chk("br0_valid", {31'h0, IFIDValid}, 32'h0);
        chk("br0_addr",  mif.IMemAddr, 32'h0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);

        // Stall two cycles while 0x08 responds.
        cyc(0, 0, 0, 0);
        chk("hold_req",   {31'h0, mif.IMemReq}, 32'h0);
        chk("hold_instr", IFIDInstruction, 32'h4);
        cyc(0, 0, 0, 0);
        chk("hold2_instr", IFIDInstruction, 32'h4);
        cyc(0, 0, 1, 1);
        chk("rel_instr", IFIDInstruction, 32'h8);
        chk("rel_pc4",   IFIDPCPlus4, 32'hC);
        chk("rel_addr2", mif.IMemAddr, 32'hC);
        cyc(0, 0, 1, 1);

        // Branch while 0x10 responds.
        cyc(1, 32'h100, 1, 1);
        chk("brz_valid", {31'h0, IFIDValid}, 32'h0);
        chk("brz_addr",  mif.IMemAddr, 32'h100);
        cyc(0, 0, 1, 1);
        chk("brz_instr", IFIDInstruction, 32'h100);

        // Branch to 0x200 during a 3-wait fetch of 0x20.
        cyc(1, 32'h20, 1, 1);
        waits = 3;
        cyc(1, 32'h200, 1, 1);
        chk("wr_addr1", mif.IMemAddr, 32'h20);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        chk("wr_addr3", mif.IMemAddr, 32'h20);
        cyc(0, 0, 1, 1);
        chk("wr_addr4", mif.IMemAddr, 32'h200);
        chk("wr_valid", {31'h0, IFIDValid}, 32'h0);
        waits = 0;
        cyc(0, 0, 1, 1);
        chk("wr_instr", IFIDInstruction, 32'h200);

        // Branch without PCWriteEnable is ignored.
        cyc(1, 32'h300, 0, 1);
        chk("nopcwe_addr",  mif.IMemAddr, 32'h208);
        chk("nopcwe_instr", IFIDInstruction, 32'h204);

        // Two redirects during a wait: the latest wins.
        waits = 2;
        cyc(1, 32'h400, 1, 1);
        cyc(1, 32'h500, 1, 1);
        cyc(0, 0, 1, 1);
        chk("latest_addr", mif.IMemAddr, 32'h500);

        // Reset in the middle of REDIRECT.
        waits = 3;
        cyc(1, 32'h600, 1, 1);
        Branch = 1'b0;
        #2 Reset = 1'b0;
        #1;
        chk("mid_rst_req",   {31'h0, mif.IMemReq}, 32'h0);
        chk("mid_rst_valid", {31'h0, IFIDValid}, 32'h0);
        waits = 0;
        @(negedge Clock); #1;
        Reset = 1'b1;
        #1;
        chk("mid_rel_addr", mif.IMemAddr, RPC);
        chk("mid_rel_req",  {31'h0, mif.IMemReq}, 32'h1);

        // PC wrap past the top of the address space.
        cyc(1, 32'hFFFF_FFFC, 1, 1);
        cyc(0, 0, 1, 1);
        chk("wrap_pc4",   IFIDPCPlus4, 32'h0);
        chk("wrap_instr", IFIDInstruction, 32'hFFFF_FFFC);
        chk("wrap_addr",  mif.IMemAddr, 32'h0);

        // Redirect while holding a stalled instruction drops it.
        cyc(0, 0, 0, 0);
        cyc(1, 32'h700, 1, 0);
        chk("hr_addr",  mif.IMemAddr, 32'h700);
        chk("hr_instr", IFIDInstruction, 32'hFFFF_FFFC);
        cyc(0, 0, 1, 1);
        chk("hr_fetch", IFIDInstruction, 32'h700);

        // Mixed wait states and stalls, model-checked.
        waits = 1;
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 32'h800, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        cyc(1, 32'h900, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        waits = 0;
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
